// File: rtl/msx_reload_pkg.sv
// rtl/msx_reload_pkg.sv - shared states, limits and size helper for the MSX reload sequencer
package msx_reload_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        REQ_A,
        REQ_B,
        CLEAR,
        HOLD
    } reload_state_t;

    localparam int SRAM_MAX_KB = 32;

    // Slot A backup SRAM is never larger than 32 kB, so bigger settings are clamped
    function automatic logic [5:0] clamp_kb(input logic [7:0] kb);
        return (kb > 8'(SRAM_MAX_KB)) ? 6'(SRAM_MAX_KB) : kb[5:0];
    endfunction

endpackage

// File: rtl/msx_reload_timer.sv
// rtl/msx_reload_timer.sv - loadable down-counter, done when CYCLES cycles have elapsed since load
module msx_reload_timer #(
    parameter int CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_done
);

    localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [W-1:0] LOAD = W'(CYCLES - 1);

    // Holds the remaining cycles; reaching zero marks the last cycle of the interval
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_cnt <= LOAD;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/msx_reload_sequencer.sv
// rtl/msx_reload_sequencer.sv - holds the MSX core in reset while cartridge ROMs reload and slot A SRAM is zeroed
module msx_reload_sequencer
    import msx_reload_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 21477,
    parameter int TIMEOUT_CYCLES = 16777216,
    parameter int RESET_HOLD     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reload,
    input  logic        rom_A_needed,
    input  logic        rom_B_needed,
    input  logic [7:0]  sram_A_size,
    output logic        load_req,
    output logic        load_slot,
    input  logic        load_ack,
    input  logic        load_err,
    output logic        sram_clr_we,
    output logic [14:0] sram_clr_addr,
    input  logic        sram_clr_wait,
    output logic        core_reset,
    output logic        busy,
    output logic        err_A,
    output logic        err_B
);

    reload_state_t r_state;
    logic          r_pending, r_rom_b;
    logic [5:0]    r_size;
    logic [15:0]   r_addr;
    logic          r_load_req, r_load_slot, r_clr_we;
    logic          r_core_reset, r_busy, r_err_a, r_err_b;

    logic          w_settle_done, w_timeout_done, w_hold_done;
    logic          w_in_seq;
    logic [5:0]    w_in_size;
    logic [15:0]   w_last_addr;

    assign w_in_size   = clamp_kb(sram_A_size);
    assign w_last_addr = {r_size, 10'd0} - 16'd1;
    assign w_in_seq    = (r_state == REQ_A) || (r_state == REQ_B) ||
                         (r_state == CLEAR) || (r_state == HOLD);

    // Settle restarts on every reload; timeout runs only while a request is outstanding
    msx_reload_timer #(.CYCLES(SETTLE_CYCLES)) u_settle (
        .clk(clk), .reset(reset),
        .i_clr(reload || (r_state != SETTLE)), .i_en(r_state == SETTLE),
        .o_done(w_settle_done)
    );

    msx_reload_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk(clk), .reset(reset),
        .i_clr(!r_load_req), .i_en(r_load_req),
        .o_done(w_timeout_done)
    );

    msx_reload_timer #(.CYCLES(RESET_HOLD)) u_hold (
        .clk(clk), .reset(reset),
        .i_clr(r_state != HOLD), .i_en(r_state == HOLD),
        .o_done(w_hold_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= SETTLE;
            r_pending    <= 1'b0;
            r_rom_b      <= 1'b0;
            r_size       <= '0;
            r_addr       <= '0;
            r_load_req   <= 1'b0;
            r_load_slot  <= 1'b0;
            r_clr_we     <= 1'b0;
            r_core_reset <= 1'b1;
            r_busy       <= 1'b1;
            r_err_a      <= 1'b0;
            r_err_b      <= 1'b0;
        end else begin
            if (reload && w_in_seq) r_pending <= 1'b1;
            case (r_state)
                IDLE: if (reload) begin
                    r_state      <= SETTLE;
                    r_core_reset <= 1'b1;
                    r_busy       <= 1'b1;
                    r_err_a      <= 1'b0;
                    r_err_b      <= 1'b0;
                end
                SETTLE: if (w_settle_done && !reload) begin
                    r_rom_b <= rom_B_needed;
                    r_size  <= w_in_size;
                    if (rom_A_needed) begin
                        r_state     <= REQ_A;
                        r_load_req  <= 1'b1;
                        r_load_slot <= 1'b0;
                    end else if (rom_B_needed) begin
                        r_state     <= REQ_B;
                        r_load_req  <= 1'b1;
                        r_load_slot <= 1'b1;
                    end else begin
                        r_state  <= (w_in_size == '0) ? HOLD : CLEAR;
                        r_clr_we <= (w_in_size != '0);
                        r_addr   <= '0;
                    end
                end
                REQ_A: if (r_load_req && (load_ack || w_timeout_done)) begin
                    r_load_req <= 1'b0;
                    r_err_a    <= r_err_a | (load_ack ? load_err : 1'b1);
                    if (r_rom_b) begin
                        r_state     <= REQ_B;
                        r_load_slot <= 1'b1;
                    end else begin
                        r_state  <= (r_size == '0) ? HOLD : CLEAR;
                        r_clr_we <= (r_size != '0);
                        r_addr   <= '0;
                    end
                end
                // Entered from REQ_A with the request low so the loader sees a fresh rising edge
                REQ_B: if (!r_load_req) begin
                    r_load_req <= 1'b1;
                end else if (load_ack || w_timeout_done) begin
                    r_load_req <= 1'b0;
                    r_err_b    <= r_err_b | (load_ack ? load_err : 1'b1);
                    r_state    <= (r_size == '0) ? HOLD : CLEAR;
                    r_clr_we   <= (r_size != '0);
                    r_addr     <= '0;
                end
                CLEAR: if (!sram_clr_wait) begin
                    if (r_addr == w_last_addr) begin
                        r_clr_we <= 1'b0;
                        r_state  <= HOLD;
                    end else begin
                        r_addr <= r_addr + 16'd1;
                    end
                end
                HOLD: if (w_hold_done) begin
                    if (r_pending || reload) begin
                        r_state   <= SETTLE;
                        r_pending <= 1'b0;
                    end else begin
                        r_state      <= IDLE;
                        r_core_reset <= 1'b0;
                        r_busy       <= 1'b0;
                    end
                end
                default: r_state <= SETTLE;
            endcase
        end
    end

    assign load_req      = r_load_req;
    assign load_slot     = r_load_slot;
    assign sram_clr_we   = r_clr_we;
    assign sram_clr_addr = r_addr[14:0];
    assign core_reset    = r_core_reset;
    assign busy          = r_busy;
    assign err_A         = r_err_a;
    assign err_B         = r_err_b;

endmodule

// File: tb/tb_msx_reload_sequencer.sv
// tb/tb_msx_reload_sequencer.sv - randomized scoreboard bench for msx_reload_sequencer
module tb_msx_reload_sequencer;

    localparam int SETTLE = 8;
    localparam int TMO    = 100;
    localparam int HOLDC  = 16;

    logic        clk = 1'b0, reset = 1'b1, reload = 1'b0;
    logic        rom_a = 1'b0, rom_b = 1'b0;
    logic [7:0]  sram_size = 8'd0;
    logic        load_req, load_slot, load_ack = 1'b0, load_err = 1'b0;
    logic        sram_clr_we, sram_clr_wait = 1'b0;
    logic [14:0] sram_clr_addr;
    logic        core_reset, busy, err_A, err_B;

    msx_reload_sequencer #(
        .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO), .RESET_HOLD(HOLDC)
    ) dut (
        .clk(clk), .reset(reset), .reload(reload),
        .rom_A_needed(rom_a), .rom_B_needed(rom_b), .sram_A_size(sram_size),
        .load_req(load_req), .load_slot(load_slot), .load_ack(load_ack), .load_err(load_err),
        .sram_clr_we(sram_clr_we), .sram_clr_addr(sram_clr_addr), .sram_clr_wait(sram_clr_wait),
        .core_reset(core_reset), .busy(busy), .err_A(err_A), .err_B(err_B)
    );

    always #5 clk = ~clk;

    // kind: 0 = load request (val = slot), 1 = zero-fill write (val = addr), 2 = core release (val = {err_B, err_A})
    typedef struct {
        int kind;
        int val;
        int t;
        bit to;
    } ev_t;

    ev_t exp_q[$];
    int  compared = 0, mismatched = 0;
    int  cyc = 0;
    int  ack_mode[2] = '{0, 0};
    int  ack_delay = 0, wait_mode = 0, stall_left = 0, stall10 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pop_ev(input string what, output ev_t e, output bit ok);
        compared++;
        ok = (exp_q.size() != 0);
        e.kind = -1; e.val = 0; e.t = -1; e.to = 1'b0;
        if (!ok) begin
            mismatched++;
            $display("FAIL unexpected_%s: DUT event at cycle %0d, required none", what, cyc);
        end else begin
            e = exp_q.pop_front();
        end
    endtask

    // Loader model: acks after a delay unless told to stay silent; also throws stray acks while idle
    int ld_cnt = 0;
    bit ld_arm = 1'b0;
    always @(negedge clk) begin
        load_ack = 1'b0;
        load_err = 1'b0;
        if (!load_req) begin
            ld_arm = 1'b0;
            if ($urandom_range(0, 7) == 0) begin
                load_ack = 1'b1;
                load_err = 1'($urandom_range(0, 1));
            end
        end else begin
            if (!ld_arm) begin
                ld_arm = 1'b1;
                ld_cnt = ack_delay;
            end
            if (ld_cnt > 0) ld_cnt--;
            else if (ack_mode[load_slot] != 2) begin
                load_ack = 1'b1;
                load_err = (ack_mode[load_slot] == 1);
            end
        end
    end

    always @(negedge clk) begin
        if (wait_mode == 1) sram_clr_wait = ($urandom_range(0, 3) == 0);
        else if (wait_mode == 2 && sram_clr_we && sram_clr_addr == 15'h0010 && stall_left > 0) begin
            sram_clr_wait = 1'b1;
            stall_left--;
        end else sram_clr_wait = 1'b0;
    end

    // Monitor
    logic        p_req = 1'b0, p_core = 1'b1, p_we = 1'b0, p_wait = 1'b0, p_slot = 1'b0;
    logic [14:0] p_addr = '0;
    int          rise_cyc = 0, last_done = 0;
    bit          rise_to = 1'b0, rise_slot = 1'b0, ok;
    ev_t         m_ev;

    always @(negedge clk) begin
        #1;
        if (reset) begin
            rise_to = 1'b0;
        end else begin
            if (load_req && !p_req) begin
                pop_ev("request", m_ev, ok);
                if (ok) begin
                    chk("req_kind", 0, m_ev.kind);
                    chk("req_slot", load_slot, m_ev.val);
                    if (m_ev.t >= 0) chk("req_time", cyc, m_ev.t);
                    rise_to = m_ev.to;
                end
                rise_cyc  = cyc;
                rise_slot = load_slot;
            end
            if (load_req && p_req) chk("slot_stable", load_slot, p_slot);
            if (!load_req && p_req) begin
                last_done = cyc;
                if (rise_to) begin
                    chk("timeout_len", cyc - rise_cyc, TMO);
                    chk("timeout_err", rise_slot ? err_B : err_A, 1);
                    rise_to = 1'b0;
                end
            end
            if (p_we && p_wait) begin
                chk("stall_we", sram_clr_we, 1);
                chk("stall_addr", sram_clr_addr, p_addr);
            end
            if (sram_clr_we && sram_clr_wait && sram_clr_addr == 15'h0010) stall10++;
            if (sram_clr_we && !sram_clr_wait) begin
                pop_ev("write", m_ev, ok);
                if (ok) begin
                    chk("wr_kind", 1, m_ev.kind);
                    chk("wr_addr", sram_clr_addr, m_ev.val);
                end
                last_done = cyc + 1;
            end
            if (!core_reset && p_core) begin
                pop_ev("release", m_ev, ok);
                if (ok) begin
                    chk("rel_kind", 2, m_ev.kind);
                    chk("rel_errs", {err_B, err_A}, m_ev.val);
                    chk("rel_busy", busy, 0);
                    chk("release_gap", cyc - last_done, HOLDC);
                end
            end
        end
        p_req = load_req; p_core = core_reset; p_we = sram_clr_we;
        p_wait = sram_clr_wait; p_addr = sram_clr_addr; p_slot = load_slot;
    end

    // Reference model: what one sequence must present, in order
    task automatic push_seq(input bit ra, input bit rb, input int size, input int t_first);
        ev_t e;
        int  n;
        if (ra) begin
            e.kind = 0; e.val = 0; e.t = t_first; e.to = (ack_mode[0] == 2);
            exp_q.push_back(e);
        end
        if (rb) begin
            e.kind = 0; e.val = 1; e.t = ra ? -1 : t_first; e.to = (ack_mode[1] == 2);
            exp_q.push_back(e);
        end
        n = ((size > 32) ? 32 : size) * 1024;
        for (int a = 0; a < n; a++) begin
            e.kind = 1; e.val = a; e.t = -1; e.to = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_rel(input bit ra, input bit rb);
        ev_t e;
        e.kind = 2; e.t = -1; e.to = 1'b0;
        e.val  = ((rb && ack_mode[1] != 0) ? 2 : 0) + ((ra && ack_mode[0] != 0) ? 1 : 0);
        exp_q.push_back(e);
    endtask

    task automatic wait_empty(input string name, input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL %s: %0d events still pending after %0d cycles, required 0", name, exp_q.size(), budget);
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic setup(input bit ra, input bit rb, input int size, input int ma, input int mb,
                         input int dly, input int wm);
        ack_mode[0] = ma; ack_mode[1] = mb; ack_delay = dly; wait_mode = wm; stall_left = 3;
        rom_a = ra; rom_b = rb; sram_size = 8'(size);
    endtask

    task automatic run(input bit ra, input bit rb, input int size, input int ma, input int mb,
                       input int dly, input int wm);
        @(negedge clk);
        setup(ra, rb, size, ma, mb, dly, wm);
        reload = 1'b1;
        push_seq(ra, rb, size, cyc + 1 + SETTLE);
        push_rel(ra, rb);
        @(negedge clk);
        reload = 1'b0;
        wait_empty("seq_done", 40000);
    endtask

    initial begin
        int k;
        int sizes[4] = '{0, 1, 2, 4};
        bit ra, rb;
        int sz, m0, m1;

        // Reset state and power-on sequence
        setup(1'b1, 1'b0, 8, 0, 0, 4, 0);
        repeat (3) @(negedge clk);
        chk("rst_core_reset", core_reset, 1);
        chk("rst_busy", busy, 1);
        chk("rst_load_req", load_req, 0);
        chk("rst_load_slot", load_slot, 0);
        chk("rst_clr_we", sram_clr_we, 0);
        chk("rst_clr_addr", sram_clr_addr, 0);
        chk("rst_err_A", err_A, 0);
        chk("rst_err_B", err_B, 0);
        reset = 1'b0;
        push_seq(1'b1, 1'b0, 8, cyc + SETTLE);
        push_rel(1'b1, 1'b0);
        wait_empty("power_on", 20000);

        // Both slots, slot A fails, no SRAM
        run(1'b1, 1'b1, 0, 1, 0, 3, 0);

        // Debounce: four pulses five cycles apart
        @(negedge clk);
        setup(1'b1, 1'b1, 1, 0, 0, 2, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            reload = 1'b1;
            if (i == 3) begin
                push_seq(1'b1, 1'b1, 1, cyc + 1 + SETTLE);
                push_rel(1'b1, 1'b1);
            end
            @(negedge clk);
            reload = 1'b0;
            if (i != 3) repeat (3) @(negedge clk);
        end
        wait_empty("debounce", 5000);

        // Timeout on slot A
        run(1'b1, 1'b0, 0, 2, 0, 0, 0);

        // Wait stall at 0x0010 and 64 kB clamp
        stall10 = 0;
        run(1'b0, 1'b0, 64, 0, 0, 0, 2);
        chk("stall_cycles_0x10", stall10, 3);

        // Reload during CLEAR reruns the whole sequence before release
        @(negedge clk);
        setup(1'b0, 1'b1, 1, 0, 0, 1, 1);
        reload = 1'b1;
        push_seq(1'b0, 1'b1, 1, cyc + 1 + SETTLE);
        @(negedge clk);
        reload = 1'b0;
        k = 0;
        while (!sram_clr_we && k < 2000) begin @(negedge clk); k++; end
        chk("clear_started", sram_clr_we, 1);
        repeat (100) @(negedge clk);
        reload = 1'b1;
        push_seq(1'b0, 1'b1, 1, -1);
        push_rel(1'b0, 1'b1);
        @(negedge clk);
        reload = 1'b0;
        wait_empty("reload_in_clear", 10000);

        // Reset mid REQ_A aborts immediately
        @(negedge clk);
        setup(1'b1, 1'b0, 1, 2, 0, 0, 0);
        reload = 1'b1;
        push_seq(1'b1, 1'b0, 0, cyc + 1 + SETTLE);
        @(negedge clk);
        reload = 1'b0;
        k = 0;
        while (!load_req && k < 200) begin @(negedge clk); k++; end
        chk("abort_req_up", load_req, 1);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("abort_load_req", load_req, 0);
        chk("abort_core_reset", core_reset, 1);
        chk("abort_busy", busy, 1);
        chk("abort_err_A", err_A, 0);
        ack_mode[0] = 0;
        reset = 1'b0;
        push_seq(1'b1, 1'b0, 1, cyc + SETTLE);
        push_rel(1'b1, 1'b0);
        wait_empty("after_abort", 10000);

        // Randomized sequences
        for (int i = 0; i < 8; i++) begin
            ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            sz = sizes[$urandom_range(0, 3)];
            if (!ra && !rb && sz == 0) sz = 1;
            m0 = $urandom_range(0, 5);
            m1 = $urandom_range(0, 5);
            run(ra, rb, sz, (m0 == 5) ? 2 : (m0 & 1), (m1 == 5) ? 2 : (m1 & 1),
                $urandom_range(0, 5), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #(1000000);
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, required completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule
